// File: rtl/move_exec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : move_exec_arbiter
// Purpose  : Owns the board register and round-robin shares one move executor
//            between N_REQ requesters, with at most one move in flight.
// Revision : 1.0 - initial release
// ============================================================================

package move_exec_arbiter_pkg;
    // 64 squares x 4-bit piece code, square 0 = a1 in bits [3:0]
    typedef logic [255:0] board_t;
    // {promotion[3:0], to[5:0], from[5:0]}
    typedef logic [15:0]  move_t;

    localparam board_t c_START_POSITION = {32'hCABEDBAC, 32'h99999999, 128'h0,
                                           32'h11111111, 32'h42365324};
endpackage

module move_exec_arbiter
    import move_exec_arbiter_pkg::*;
#(
    parameter int     N_REQ          = 2,
    parameter int     TIMEOUT_CYCLES = 1023,
    parameter board_t START_BOARD    = c_START_POSITION
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  board_t                     load_board_in,
    input  logic                       load_valid_in,
    output logic                       load_ready_out,
    input  move_t [N_REQ-1:0]          req_move_in,
    input  logic [N_REQ-1:0]           req_valid_in,
    output logic [N_REQ-1:0]           req_ready_out,
    output board_t                     exec_board_out,
    output move_t                      exec_move_out,
    output logic                       exec_valid_out,
    input  board_t                     exec_board_in,
    input  logic                       exec_valid_in,
    output board_t                     board_out,
    output logic                       board_valid_out,
    output logic [$clog2(N_REQ)-1:0]   board_tag_out,
    output logic                       busy_out,
    output logic                       timeout_out
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    localparam logic [TAG_W:0]   c_N_REQ_EXT = (TAG_W + 1)'(N_REQ);
    localparam logic [TAG_W-1:0] c_LAST_TAG  = TAG_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    board_t           r_board;
    logic [TAG_W-1:0] r_ptr;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;

    logic             w_grant_found;
    logic [TAG_W-1:0] w_grant_idx;
    logic             w_load_fire;
    logic             w_grant_fire;
    logic             w_exec_done;
    logic             w_timeout_hit;
    logic [TAG_W-1:0] w_tag_inc;

    // Scan from the pointer upward with wrap-around; first valid requester wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            logic [TAG_W:0] v_idx;
            v_idx = {1'b0, r_ptr} + (TAG_W + 1)'(k);
            if (v_idx >= c_N_REQ_EXT) begin
                v_idx = v_idx - c_N_REQ_EXT;
            end
            if (!w_grant_found && req_valid_in[v_idx[TAG_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_idx[TAG_W-1:0];
            end
        end
    end

    // A pending load blocks grants for the cycle it is accepted.
    assign w_load_fire   = (r_state == c_ST_IDLE) && load_valid_in;
    assign w_grant_fire  = (r_state == c_ST_IDLE) && !load_valid_in && w_grant_found;
    assign w_exec_done   = (r_state == c_ST_WAIT) && exec_valid_in;
    assign w_timeout_hit = (r_state == c_ST_WAIT) && !exec_valid_in && (r_cnt == c_CNT_LAST);
    assign w_tag_inc     = (r_tag == c_LAST_TAG) ? '0 : r_tag + TAG_W'(1);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant_fire) w_state_next = c_ST_ISSUE;
            c_ST_ISSUE: w_state_next = c_ST_WAIT;
            c_ST_WAIT:  if (w_exec_done || w_timeout_hit) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready_out = (r_state == c_ST_IDLE);
        exec_valid_out = (r_state == c_ST_ISSUE);
        busy_out       = (r_state != c_ST_IDLE);
        req_ready_out  = '0;
        if (w_grant_fire) begin
            req_ready_out[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_board         <= START_BOARD;
            board_out       <= START_BOARD;
            board_valid_out <= 1'b0;
            board_tag_out   <= '0;
            exec_move_out   <= '0;
            r_tag           <= '0;
            r_ptr           <= '0;
            r_cnt           <= '0;
            timeout_out     <= 1'b0;
        end else begin
            board_valid_out <= 1'b0;
            if (w_load_fire) begin
                r_board <= load_board_in;
            end
            if (w_grant_fire) begin
                exec_move_out <= req_move_in[w_grant_idx];
                r_tag         <= w_grant_idx;
            end
            if (r_state == c_ST_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == c_ST_WAIT) && !exec_valid_in) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_exec_done) begin
                r_board         <= exec_board_in;
                board_out       <= exec_board_in;
                board_valid_out <= 1'b1;
                board_tag_out   <= r_tag;
                r_ptr           <= w_tag_inc;
            end
            // Abandoned move: board untouched, but the requester still loses its turn.
            if (w_timeout_hit) begin
                timeout_out <= 1'b1;
                r_ptr       <= w_tag_inc;
            end
        end
    end

    assign exec_board_out = r_board;

endmodule
`default_nettype wire

// File: tb/tb_move_exec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_exec_arbiter
// Purpose  : Scoreboard bench for move_exec_arbiter with an executor model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_exec_arbiter;
    import move_exec_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int TW = $clog2(N);
    localparam int TO = 8;

    logic              clk_in = 1'b0;
    logic              rst_in;
    board_t            load_board_in;
    logic              load_valid_in;
    logic              load_ready_out;
    move_t [N-1:0]     req_move_in;
    logic [N-1:0]      req_valid_in;
    logic [N-1:0]      req_ready_out;
    board_t            exec_board_out;
    move_t             exec_move_out;
    logic              exec_valid_out;
    board_t            exec_board_in;
    logic              exec_valid_in;
    board_t            board_out;
    logic              board_valid_out;
    logic [TW-1:0]     board_tag_out;
    logic              busy_out;
    logic              timeout_out;

    move_exec_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .load_board_in(load_board_in), .load_valid_in(load_valid_in), .load_ready_out(load_ready_out),
        .req_move_in(req_move_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .exec_board_out(exec_board_out), .exec_move_out(exec_move_out), .exec_valid_out(exec_valid_out),
        .exec_board_in(exec_board_in), .exec_valid_in(exec_valid_in),
        .board_out(board_out), .board_valid_out(board_valid_out), .board_tag_out(board_tag_out),
        .busy_out(busy_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct { move_t mv; board_t brd; int unsigned at; } issue_t;
    typedef struct { board_t brd; int tag; } done_t;

    issue_t      q_issue[$];
    done_t       q_done[$];
    int unsigned q_resp[$];
    int          grant_tags[$];

    int          n_checks = 0;
    int          n_fail   = 0;

    board_t      model_board = c_START_POSITION;
    int          model_ptr   = 0;
    int          n_grants    = 0;
    int unsigned last_grant_cyc, last_load_cyc, last_done_cyc;
    int unsigned smp_cyc;
    logic        smp_timeout, smp_busy;

    bit          exec_en  = 1'b1;
    int          exec_lat = 0;
    int          inject_seq = 0;
    int          inject_ack = 0;
    board_t      inject_board;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic board_t apply_move(input board_t b, input move_t m);
        board_t     r;
        logic [3:0] pc;
        r  = b;
        pc = b[int'(m[5:0]) * 4 +: 4];
        r[int'(m[5:0]) * 4 +: 4]  = 4'h0;
        r[int'(m[11:6]) * 4 +: 4] = (m[15:12] != 4'h0) ? m[15:12] : pc;
        return r;
    endfunction

    function automatic int predict(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic board_t rand_board();
        board_t b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic move_t rand_move();
        return move_t'($urandom);
    endfunction

    // Executor model: applies the move after a latency, or injects a stray pulse.
    initial begin
        board_t b;
        int     l;
        exec_valid_in = 1'b0;
        exec_board_in = '0;
        forever begin
            @(negedge clk_in);
            if (inject_seq != inject_ack) begin
                @(posedge clk_in); #1;
                exec_valid_in = 1'b1;
                exec_board_in = inject_board;
                @(posedge clk_in); #1;
                exec_valid_in = 1'b0;
                inject_ack    = inject_seq;
            end else if (exec_valid_out && exec_en) begin
                b = apply_move(exec_board_out, exec_move_out);
                l = (exec_lat > 0) ? exec_lat : int'($urandom_range(1, 6));
                repeat (l) @(posedge clk_in);
                #1;
                exec_valid_in = 1'b1;
                exec_board_in = b;
                q_resp.push_back(cyc);
                @(posedge clk_in); #1;
                exec_valid_in = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an issue or a result.
    initial begin
        issue_t      ei;
        done_t       ed;
        int unsigned rc;
        forever begin
            @(negedge clk_in);
            chk("load_ready_vs_busy", load_ready_out, !busy_out);
            if (exec_valid_out) begin
                chk("exec_valid_expected", q_issue.size() != 0, 1'b1);
                if (q_issue.size() != 0) begin
                    ei = q_issue.pop_front();
                    chk("exec_move", exec_move_out, ei.mv);
                    chk("exec_board_at_issue", exec_board_out, ei.brd);
                    chk("exec_latency", cyc, ei.at + 1);
                end
            end
            if (board_valid_out) begin
                last_done_cyc = cyc;
                chk("board_valid_expected", q_done.size() != 0, 1'b1);
                if (q_done.size() != 0) begin
                    ed = q_done.pop_front();
                    chk("board_out", board_out, ed.brd);
                    chk("board_tag", board_tag_out, ed.tag);
                    if (q_resp.size() != 0) begin
                        rc = q_resp.pop_front();
                        chk("done_latency", cyc, rc + 1);
                    end
                end
            end
        end
    end

    // One cycle: evaluate handshakes at the falling edge, then release accepted inputs.
    task automatic step();
        int          g;
        bit          load_taken;
        logic [N-1:0] exp_rdy;
        board_t      nb;
        issue_t      it;
        done_t       dn;
        g          = -1;
        load_taken = 1'b0;
        @(negedge clk_in);
        smp_cyc     = cyc;
        smp_timeout = timeout_out;
        smp_busy    = busy_out;
        if (rst_in) begin
            if (load_ready_out && load_valid_in) begin
                chk("ready_during_load", req_ready_out, '0);
                model_board   = load_board_in;
                load_taken    = 1'b1;
                last_load_cyc = cyc;
            end else if (load_ready_out && req_valid_in != '0) begin
                g       = predict(req_valid_in, model_ptr);
                exp_rdy = '0;
                exp_rdy[g] = 1'b1;
                chk("grant", req_ready_out, exp_rdy);
                if (req_ready_out != exp_rdy) begin
                    g = -1;
                    if ($onehot(req_ready_out)) begin
                        for (int i = 0; i < N; i++) if (req_ready_out[i]) g = i;
                    end
                end
                if (g >= 0) begin
                    last_grant_cyc = cyc;
                    n_grants++;
                    grant_tags.push_back(g);
                    it.mv  = req_move_in[g];
                    it.brd = model_board;
                    it.at  = cyc;
                    q_issue.push_back(it);
                    if (exec_en) begin
                        nb     = apply_move(model_board, req_move_in[g]);
                        dn.brd = nb;
                        dn.tag = g;
                        q_done.push_back(dn);
                        model_board = nb;
                    end
                    model_ptr = (g + 1) % N;
                end
            end else begin
                chk("ready_idle", req_ready_out, '0);
            end
        end
        @(posedge clk_in); #1;
        if (load_taken) load_valid_in = 1'b0;
        if (g >= 0) req_valid_in[g] = 1'b0;
    endtask

    task automatic wait_grant(input int budget);
        int start;
        int n;
        start = n_grants;
        n     = 0;
        while (n_grants == start && n < budget) begin
            step();
            n++;
        end
        chk("grant_within_budget", n_grants != start, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        bit idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            step();
            n++;
            idle = (q_issue.size() == 0) && (q_done.size() == 0) && (req_valid_in == '0) &&
                   !load_valid_in && load_ready_out && !exec_valid_in && (inject_seq == inject_ack);
        end
        chk("drain_within_budget", idle, 1'b1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        board_t bo;
        board_t lb;
        move_t  e2e4;
        int     gc;
        int     n;
        int     start;

        rst_in        = 1'b0;
        load_board_in = '0;
        load_valid_in = 1'b0;
        req_move_in   = '0;
        req_valid_in  = '0;
        step();
        step();
        chk("rst_board_out", board_out, c_START_POSITION);
        chk("rst_exec_board", exec_board_out, c_START_POSITION);
        chk("rst_board_valid", board_valid_out, 1'b0);
        chk("rst_exec_valid", exec_valid_out, 1'b0);
        chk("rst_timeout", timeout_out, 1'b0);
        chk("rst_tag", board_tag_out, '0);
        chk("rst_exec_move", exec_move_out, '0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_load_ready", load_ready_out, 1'b1);
        rst_in = 1'b1;

        // Single move e2e4 from requester 0, executor latency 3.
        exec_lat       = 3;
        e2e4           = {4'h0, 6'd28, 6'd12};
        req_move_in[0] = e2e4;
        req_valid_in   = 3'b001;
        wait_grant(20);
        gc = int'(last_grant_cyc);
        wait_idle(40);
        chk("e2e4_done_latency", last_done_cyc - gc, 5);
        chk("e2e4_board_out", board_out, apply_move(c_START_POSITION, e2e4));
        chk("e2e4_exec_board_after", exec_board_out, model_board);

        // Two requesters held valid: grants must alternate.
        exec_lat = 0;
        start    = grant_tags.size();
        n        = 0;
        while (grant_tags.size() < start + 4 && n < 200) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid_in[i]) begin
                    req_move_in[i]  = rand_move();
                    req_valid_in[i] = 1'b1;
                end
            end
            step();
            n++;
        end
        req_valid_in = '0;
        chk("alternation_grants_seen", grant_tags.size() >= start + 4, 1'b1);
        for (int k = start + 1; k < start + 4 && k < grant_tags.size(); k++) begin
            chk("alternate_grant", grant_tags[k] != grant_tags[k-1], 1'b1);
        end
        wait_idle(60);

        // Load and request in the same IDLE cycle: load wins, request follows.
        lb             = rand_board();
        load_board_in  = lb;
        load_valid_in  = 1'b1;
        req_move_in[1] = rand_move();
        req_valid_in   = 3'b010;
        step();
        chk("load_installed", exec_board_out, lb);
        wait_grant(5);
        chk("grant_after_load_cycle", last_grant_cyc, last_load_cyc + 1);
        chk("grant_after_load_tag", grant_tags[grant_tags.size()-1], 1);
        wait_idle(40);

        // Silent executor: timeout after TO cycles in WAIT.
        exec_en        = 1'b0;
        bo             = board_out;
        req_move_in[2] = rand_move();
        req_valid_in   = 3'b100;
        chk("timeout_low_initially", timeout_out, 1'b0);
        wait_grant(10);
        gc = int'(last_grant_cyc);
        n  = 0;
        while (smp_cyc < gc + 1 + TO && n < 50) begin
            step();
            n++;
        end
        chk("timeout_low_before_expiry", smp_timeout, 1'b0);
        step();
        chk("timeout_cycle", smp_cyc, gc + 2 + TO);
        chk("timeout_set", smp_timeout, 1'b1);
        chk("idle_after_timeout", smp_busy, 1'b0);
        chk("board_kept_on_timeout", exec_board_out, model_board);
        chk("board_out_kept_on_timeout", board_out, bo);
        exec_en        = 1'b1;
        req_move_in[0] = rand_move();
        req_valid_in   = 3'b001;
        wait_grant(10);
        wait_idle(40);
        chk("timeout_sticky", timeout_out, 1'b1);

        // Reset during WAIT, then a late executor response.
        exec_en        = 1'b0;
        req_move_in[1] = rand_move();
        req_valid_in   = 3'b010;
        wait_grant(10);
        repeat (3) step();
        rst_in = 1'b0;
        step();
        step();
        rst_in       = 1'b1;
        model_board  = c_START_POSITION;
        model_ptr    = 0;
        exec_en      = 1'b1;
        inject_board = rand_board();
        inject_seq++;
        repeat (5) step();
        chk("late_resp_board_out", board_out, c_START_POSITION);
        chk("late_resp_exec_board", exec_board_out, c_START_POSITION);
        chk("late_resp_busy", busy_out, 1'b0);
        chk("late_resp_timeout_cleared", timeout_out, 1'b0);
        chk("late_resp_tag", board_tag_out, '0);

        // Spurious executor pulse while IDLE.
        wait_idle(20);
        bo           = board_out;
        inject_board = rand_board();
        inject_seq++;
        repeat (4) step();
        chk("spurious_board_out", board_out, bo);
        chk("spurious_exec_board", exec_board_out, model_board);
        chk("spurious_busy", smp_busy, 1'b0);

        // Randomised traffic with occasional loads.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid_in[i] && $urandom_range(0, 99) < 40) begin
                    req_move_in[i]  = rand_move();
                    req_valid_in[i] = 1'b1;
                end
            end
            if (!load_valid_in && $urandom_range(0, 99) < 3) begin
                load_board_in = rand_board();
                load_valid_in = 1'b1;
            end
            step();
        end
        wait_idle(300);

        chk("issue_queue_drained", q_issue.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        chk("final_board", exec_board_out, model_board);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
